alu_muldiv: RTL and testbench

- Iterative multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Consumes the same A/B operands for the MULT/DIV opcode class; the ALU leaves that class unimplemented.
- Produces a 64-bit result as HI/LO registers via a valid/ready handshake; the EX stage holds its operation and stalls while the result is outstanding.
- Radix-2 algorithm: one bit per cycle, fixed latency.

---
 rtl/alu_muldiv.sv | 154 +++++++++++++++
 tb/tb_alu_muldiv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit: one bit per cycle, HI/LO result via valid/ready.
// Works on operand magnitudes; signs are restored in a single FIX cycle.
module alu_muldiv #(
  parameter int OPR_L = 32,
  parameter int CNT_L = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [OPR_L-1:0] A,
  input  logic [OPR_L-1:0] B,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPR_L-1:0] hi,
  output logic [OPR_L-1:0] lo,
  output logic             dbz
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [OPR_L-1:0]     ma_q, ma_d, mb_q, mb_d;
  logic [2*OPR_L-1:0]   acc_q, acc_d;
  logic [CNT_L-1:0]     cnt_q, cnt_d;
  logic [OPR_L-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 dbz_q, dbz_d;

  // request-side sign/magnitude extraction (op[0]=1 means unsigned)
  logic             sa_in, sb_in;
  logic [OPR_L-1:0] abs_a, abs_b;
  assign sa_in = ~op[0] & A[OPR_L-1];
  assign sb_in = ~op[0] & B[OPR_L-1];
  assign abs_a = sa_in ? (~A + 1'b1) : A;
  assign abs_b = sb_in ? (~B + 1'b1) : B;

  // multiply: acc = {partial product, remaining multiplier bits}
  logic [OPR_L:0]     mul_sum;
  logic [2*OPR_L-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc_q[2*OPR_L-1:OPR_L]} + (acc_q[0] ? {1'b0, ma_q} : {(OPR_L+1){1'b0}});
  assign mul_nxt = {mul_sum, acc_q[OPR_L-1:1]};

  // divide: acc = {remainder, dividend/quotient}; shifted remainder needs OPR_L+1 bits
  logic [OPR_L:0]     rem_sh, div_diff;
  logic               div_ok;
  logic [2*OPR_L-1:0] div_nxt;
  assign rem_sh   = acc_q[2*OPR_L-1:OPR_L-1];
  assign div_diff = rem_sh - {1'b0, mb_q};
  assign div_ok   = ~div_diff[OPR_L];
  assign div_nxt  = {div_ok ? div_diff[OPR_L-1:0] : rem_sh[OPR_L-1:0], acc_q[OPR_L-2:0], div_ok};

  // sign fix-up; the original dividend is rebuilt from sign+magnitude for divide-by-zero
  logic               sgn_op, q_neg, r_neg, is_dbz;
  logic [2*OPR_L-1:0] prod_fix;
  logic [OPR_L-1:0]   quo_raw, rem_raw, quo_fix, rem_fix, a_orig;
  assign sgn_op   = ~op_q[0];
  assign q_neg    = sgn_op & (sa_q ^ sb_q);
  assign r_neg    = sgn_op & sa_q;
  assign prod_fix = q_neg ? (~acc_q + 1'b1) : acc_q;
  assign quo_raw  = acc_q[OPR_L-1:0];
  assign rem_raw  = acc_q[2*OPR_L-1:OPR_L];
  assign quo_fix  = q_neg ? (~quo_raw + 1'b1) : quo_raw;
  assign rem_fix  = r_neg ? (~rem_raw + 1'b1) : rem_raw;
  assign a_orig   = sa_q ? (~ma_q + 1'b1) : ma_q;
  assign is_dbz   = op_q[1] & (mb_q == '0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_d    = op;
          sa_d    = sa_in;
          sb_d    = sb_in;
          ma_d    = abs_a;
          mb_d    = abs_b;
          acc_d   = {{OPR_L{1'b0}}, (op[1] ? abs_a : abs_b)};
          cnt_d   = CNT_L'(OPR_L);
          state_d = (op[1] && B == '0) ? S_FIX : S_RUN;
        end
        S_RUN: begin
          cnt_d = cnt_q - 1'b1;
          acc_d = op_q[1] ? div_nxt : mul_nxt;
          if (cnt_q == CNT_L'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          dbz_d   = is_dbz;
          state_d = S_DONE;
          if (is_dbz) begin
            hi_d = a_orig;
            lo_d = '1;
          end else if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*OPR_L-1:OPR_L];
            lo_d = prod_fix[OPR_L-1:0];
          end
        end
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbz       = dbz_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: vector table + random ops through a scoreboard, then flush/backpressure/reset sequences.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] A = '0, B = '0;
  logic         in_ready, out_valid, dbz;
  logic [W-1:0] hi, lo;

  alu_muldiv #(.OPR_L(W), .CNT_L(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .A(A), .B(B),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .hi(hi), .lo(lo), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi, lo;
    logic         dbz;
    int           lat;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] hi, lo;
    logic         dbz;
    int           lat;
  } vec_t;

  exp_t sbq[$];
  int   npass = 0, ntot = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Independent reference: 64-bit integer arithmetic (truncating division).
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint xa, xb;
    logic [63:0] p, q, r;
    e.dbz = 1'b0;
    e.lat = 34;
    xa = o[0] ? {32'b0, a} : {{32{a[31]}}, a};
    xb = o[0] ? {32'b0, b} : {{32{b[31]}}, b};
    if (!o[1]) begin
      p = 64'(xa * xb);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.dbz = 1'b1;
      e.lat = 2;
      e.hi  = a;
      e.lo  = '1;
    end else begin
      q = 64'(xa / xb);
      r = 64'(xa % xb);
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, input bit push);
    @(negedge clk);
    chk("in_ready_before_req", in_ready, 1);
    in_valid = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
    if (push) sbq.push_back(e);
  endtask

  // Called #1 after the accepting edge (edge 1); n tracks the edge index.
  task automatic collect(input string tag);
    exp_t e;
    int n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      chk({tag, "_timeout"}, 0, 1);
      if (sbq.size() > 0) void'(sbq.pop_front());
      return;
    end
    if (sbq.size() == 0) begin
      chk({tag, "_unexpected_out"}, 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_latency"}, n, e.lat);
    chk({tag, "_hi"}, hi, e.hi);
    chk({tag, "_lo"}, lo, e.lo);
    chk({tag, "_dbz"}, dbz, e.dbz);
  endtask

  task automatic take_result(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "_valid_cleared"}, out_valid, 0);
    chk({tag, "_ready_after"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    exp_t e;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    bit seen;

    tbl[0] = '{2'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34};
    tbl[1] = '{2'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 34};
    tbl[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    tbl[3] = '{2'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 34};
    tbl[4] = '{2'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, 2};
    tbl[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    tbl[6] = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2};
    tbl[7] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    tbl[8] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_out_valid", out_valid, 0);
    @(negedge clk); rst = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      e = '{tbl[i].hi, tbl[i].lo, tbl[i].dbz, tbl[i].lat};
      issue(tbl[i].op, tbl[i].a, tbl[i].b, e, 1);
      collect($sformatf("vec%0d", i));
      take_result($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      ro = 2'(i);
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'h0 : (ro[1] ? 32'($urandom_range(1, 1000)) : $urandom);
      issue(ro, ra, rb, model(ro, ra, rb), 1);
      collect($sformatf("rnd%0d", i));
      take_result($sformatf("rnd%0d", i));
    end

    // flush in IDLE blocks accept
    @(negedge clk); in_valid = 1'b1; flush = 1'b1; op = 2'd1; A = 32'd3; B = 32'd5;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 chk("idle_flush_no_start", in_ready, 1);

    // backpressure: result held, requests ignored, no accept on the releasing edge
    e = model(2'd1, 32'h00010000, 32'h00030000);
    issue(2'd1, 32'h00010000, 32'h00030000, e, 1);
    collect("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); in_valid = 1'b1; op = 2'd0; A = $urandom; B = $urandom;
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, dbz, hi, lo}, {1'b1, 1'b0, 1'b0, 32'h3, 32'h0});
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1 chk("bp_no_same_edge_accept", in_ready, 1);

    // flush in DONE drops the result but keeps hi/lo
    issue(2'd3, 32'd100, 32'd7, model(2'd3, 32'd100, 32'd7), 1);
    collect("done_flush");
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("done_flush_valid", out_valid, 0);
    chk("done_flush_in_ready", in_ready, 1);
    chk("done_flush_keep", {hi, lo}, {32'd2, 32'd14});

    // flush on iteration 15 of a MULT
    issue(2'd0, 32'h12345678, 32'h9ABCDEF0, e, 0);
    repeat (14) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("run_flush_no_valid", seen, 0);
    chk("run_flush_keep", {hi, lo}, {32'd2, 32'd14});
    chk("run_flush_in_ready", in_ready, 1);
    issue(2'd0, 32'hFFFFFFFF, 32'h2, model(2'd0, 32'hFFFFFFFF, 32'h2), 1);
    collect("after_flush");
    take_result("after_flush");

    // asynchronous reset between edges mid-RUN
    issue(2'd1, 32'h00012345, 32'h00006789, e, 0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_out", {out_valid, dbz, hi, lo}, 65'h0);
    @(negedge clk); rst = 1'b1;
    #1 chk("async_rst_in_ready", in_ready, 1);
    issue(2'd1, 32'd3, 32'd5, '{32'd0, 32'd15, 1'b0, 34}, 1);
    collect("post_rst");
    take_result("post_rst");

    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
